mips_cpu_hilo_ctrl: RTL and testbench

- Owns the architectural HI/LO registers and sequences all MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO traffic for the core.
- Drives operands to the existing combinational signed/unsigned multiplier and waits a fixed settling latency before capturing its 64-bit product.
- Contains an iterative 32-cycle restoring divider.
- Raises a stall to the pipeline whenever a HI/LO access or a new operation arrives while an operation is still in flight.

---
 rtl/mips_cpu_hilo_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mips_cpu_hilo_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_hilo_ctrl.sv
// HI/LO register owner: sequences multiply (external array), divide (iterative)
// and MTHI/MTLO traffic, and stalls the pipeline while an operation is in flight.
module mips_cpu_hilo_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        op_ready,
    input  logic        mf_valid,
    input  logic        mf_sel,
    output logic [31:0] rd_data,
    input  logic        abort,
    output logic        busy,
    output logic        stall,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_sign,
    input  logic [63:0] mul_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE,
        MUL_WAIT,
        DIV_RUN,
        DIV_FIX
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  cnt;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic [31:0] rem;
    logic        q_neg;
    logic        r_neg;
    logic        div_zero;
    logic        accept;
    logic        is_mul;
    logic        is_div;
    logic        div_signed;
    logic [32:0] trial;
    logic [32:0] diff;

    assign busy     = (state != IDLE);
    assign op_ready = !busy;
    assign stall    = busy && (op_valid || mf_valid);
    assign rd_data  = mf_sel ? hi : lo;

    assign accept     = op_valid && !busy && !abort;
    assign is_mul     = (op_code[2:1] == 2'b00);
    assign is_div     = (op_code[2:1] == 2'b01);
    assign div_signed = (op_code == 3'd2);

    // Dividend bits enter the remainder from the top of quo; quotient bits
    // fill quo from the bottom, so quo ends up holding the quotient.
    assign trial = {rem, quo[31]};
    assign diff  = trial - {1'b0, dvs};

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept && is_mul) begin
                        state_next = MUL_WAIT;
                    end else if (accept && is_div) begin
                        state_next = (rt_data == 32'd0) ? DIV_FIX : DIV_RUN;
                    end
                end
                MUL_WAIT: begin
                    if (cnt == 5'd0) state_next = IDLE;
                end
                DIV_RUN: begin
                    if (cnt == 5'd31) state_next = DIV_FIX;
                end
                DIV_FIX: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            hi       <= '0;
            lo       <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            mul_sign <= 1'b0;
            cnt      <= '0;
            quo      <= '0;
            dvs      <= '0;
            rem      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state <= state_next;
            if (!abort) begin
                unique case (state)
                    IDLE: begin
                        if (accept) begin
                            case (op_code)
                                3'd0, 3'd1: begin
                                    mul_a    <= rs_data;
                                    mul_b    <= rt_data;
                                    mul_sign <= (op_code == 3'd0);
                                    cnt      <= 5'(MUL_LAT - 1);
                                end
                                3'd2, 3'd3: begin
                                    quo <= (div_signed && rs_data[31]) ? -rs_data : rs_data;
                                    dvs <= (div_signed && rt_data[31]) ? -rt_data : rt_data;
                                    q_neg    <= div_signed && (rs_data[31] ^ rt_data[31]);
                                    r_neg    <= div_signed && rs_data[31];
                                    rem      <= '0;
                                    cnt      <= '0;
                                    div_zero <= (rt_data == 32'd0);
                                end
                                3'd4: hi <= rs_data;
                                3'd5: lo <= rs_data;
                                default: ;
                            endcase
                        end
                    end
                    MUL_WAIT: begin
                        if (cnt == 5'd0) begin
                            {hi, lo} <= mul_out;
                        end else begin
                            cnt <= cnt - 5'd1;
                        end
                    end
                    DIV_RUN: begin
                        if (!diff[32]) begin
                            rem <= diff[31:0];
                            quo <= {quo[30:0], 1'b1};
                        end else begin
                            rem <= trial[31:0];
                            quo <= {quo[30:0], 1'b0};
                        end
                        cnt <= cnt + 5'd1;
                    end
                    DIV_FIX: begin
                        if (!div_zero) begin
                            hi <= r_neg ? -rem : rem;
                            lo <= q_neg ? -quo : quo;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mips_cpu_hilo_ctrl.sv
// Bench for mips_cpu_hilo_ctrl: directed and random ops, arithmetic reference
// model feeding a queue of expected completions checked by a monitor.
module tb_mips_cpu_hilo_ctrl;

    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        op_ready;
    logic        mf_valid;
    logic        mf_sel;
    logic [31:0] rd_data;
    logic        abort;
    logic        busy;
    logic        stall;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_sign;
    logic [63:0] mul_out;
    logic [31:0] hi;
    logic [31:0] lo;

    mips_cpu_hilo_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .op_valid(op_valid), .op_code(op_code),
        .rs_data(rs_data), .rt_data(rt_data),
        .op_ready(op_ready), .mf_valid(mf_valid), .mf_sel(mf_sel),
        .rd_data(rd_data), .abort(abort), .busy(busy), .stall(stall),
        .mul_a(mul_a), .mul_b(mul_b), .mul_sign(mul_sign),
        .mul_out(mul_out), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Combinational multiplier as it exists in the core
    assign mul_out = mul_sign
        ? ({{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b})
        : ({32'b0, mul_a} * {32'b0, mul_b});

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          blen;
        bit          chk_mul;
        logic [31:0] ma;
        logic [31:0] mb;
        bit          ms;
    } exp_t;

    exp_t        sq[$];
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act !== req) $display("FAIL %s: got %h required %h @%0t", name, act, req, $time);
        else n_pass++;
    endtask

    // Reference: architectural effect of one op, straight from MIPS semantics
    task automatic model(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                         input int k, output exp_t e);
        longint      sa, sb, q, r;
        logic [63:0] p;
        e = '{hi: m_hi, lo: m_lo, blen: 0, chk_mul: 0, ma: a, mb: b, ms: 0};
        case (code)
            3'd0, 3'd1: begin
                sa = (code == 3'd0) ? longint'($signed(a)) : longint'({32'b0, a});
                sb = (code == 3'd0) ? longint'($signed(b)) : longint'({32'b0, b});
                p = 64'(sa * sb);
                e.hi = p[63:32]; e.lo = p[31:0];
                e.blen = MUL_LAT; e.chk_mul = 1; e.ms = (code == 3'd0);
            end
            3'd2, 3'd3: begin
                if (b == 0) begin
                    e.blen = 1;
                end else begin
                    sa = (code == 3'd2) ? longint'($signed(a)) : longint'({32'b0, a});
                    sb = (code == 3'd2) ? longint'($signed(b)) : longint'({32'b0, b});
                    q = sa / sb;
                    r = sa % sb;
                    e.lo = q[31:0]; e.hi = r[31:0];
                    e.blen = 33;
                end
            end
            3'd4: e.hi = a;
            3'd5: e.lo = a;
            default: ;
        endcase
        if (k >= 0) begin
            e.hi = m_hi; e.lo = m_lo; e.blen = k + 1;
        end
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    // Present an op, hold it under stall until taken, optionally abort k cycles after E0
    task automatic issue(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                         input int k);
        exp_t e;
        int   n = 0;
        op_valid = 1'b1; op_code = code; rs_data = a; rt_data = b;
        forever begin
            @(negedge clk);
            if (op_ready) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 64'(n), 64'd0);
                op_valid = 1'b0;
                return;
            end
        end
        if (mf_valid) chk("rd_data_pre", rd_data, mf_sel ? m_hi : m_lo);
        model(code, a, b, k, e);
        sq.push_back(e);
        @(posedge clk); #1;
        op_valid = 1'b0; rs_data = $urandom; rt_data = $urandom;
        op_code = 3'($urandom_range(0, 7));
        if (k >= 0) begin
            repeat (k) @(posedge clk);
            #1 abort = 1'b1;
            @(posedge clk);
            #1 abort = 1'b0;
        end
    endtask

    // Monitor: a completion is busy falling, or an accepted op that never raised busy
    initial begin
        bit   prev_busy = 0;
        bit   acc_prev = 0;
        int   blen = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_busy = 0; acc_prev = 0; blen = 0;
            end else begin
                chk("op_ready", op_ready, !busy);
                chk("stall", stall, busy && (op_valid || mf_valid));
                if (busy) blen++;
                if (!busy && (prev_busy || acc_prev)) begin
                    if (sq.size() == 0) begin
                        chk("unexpected_completion", 64'd1, 64'd0);
                    end else begin
                        e = sq.pop_front();
                        chk("hi", hi, e.hi);
                        chk("lo", lo, e.lo);
                        chk("busy_cycles", 64'(blen), 64'(e.blen));
                        chk("rd_data", rd_data, mf_sel ? e.hi : e.lo);
                        if (e.chk_mul) begin
                            chk("mul_a", mul_a, e.ma);
                            chk("mul_b", mul_b, e.mb);
                            chk("mul_sign", mul_sign, e.ms);
                        end
                    end
                    blen = 0;
                end
                acc_prev = op_valid && op_ready && !abort;
                prev_busy = busy;
            end
        end
    end

    initial begin
        int n;
        logic [2:0]  code;
        logic [31:0] a, b;
        int          k;
        reset_n = 1'b0; op_valid = 1'b0; op_code = '0; rs_data = '0; rt_data = '0;
        mf_valid = 1'b0; mf_sel = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        chk("rst_mul_sign", mul_sign, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        issue(3'd0, 32'hFFFF_FFFE, 32'h3, -1);
        issue(3'd3, 32'd100, 32'd7, -1);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, -1);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        issue(3'd3, 32'd5, 32'd0, -1);
        issue(3'd2, 32'hFFFF_0000, 32'd0, -1);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);

        // Read and a second op held under stall for a whole divide
        issue(3'd2, 32'd1000, 32'd7, -1);
        mf_valid = 1'b1; mf_sel = 1'b0;
        issue(3'd4, 32'h0000_CAFE, 32'd0, -1);
        issue(3'd5, 32'hDEAD_BEEF, 32'd0, -1);
        mf_valid = 1'b0;

        issue(3'd4, 32'h0000_1234, 32'd0, -1);
        issue(3'd0, 32'd7, 32'd9, 0);
        issue(3'd3, 32'd99, 32'd4, 10);
        issue(3'd2, 32'hFFFF_FF00, 32'd3, 32);
        issue(3'd6, 32'h5555_5555, 32'd1, -1);

        // Asynchronous reset in the middle of a divide
        issue(3'd2, 32'd12345, 32'd11, -1);
        repeat (10) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        sq.delete();
        m_hi = '0; m_lo = '0;
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        chk("arst_busy", busy, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            mf_valid = 1'($urandom_range(0, 1));
            mf_sel   = 1'($urandom_range(0, 1));
            code = 3'($urandom_range(0, 7));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(1, 20));
                1: b = 32'd0;
                2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
                default: b = $urandom;
            endcase
            k = -1;
            if ($urandom_range(0, 7) == 0) begin
                if (code <= 3'd1 && MUL_LAT >= 2) k = $urandom_range(0, MUL_LAT - 2);
                else if ((code == 3'd2 || code == 3'd3) && b != 0) k = $urandom_range(0, 32);
            end
            issue(code, a, b, k);
        end

        n = 0;
        while (sq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(sq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
